// File: rtl/uart_pkg.sv
// Shared types and constants for the 34-bit UART frame transmitter.
package uart_pkg;

  localparam int unsigned FRAME_BITS           = 34;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  typedef struct packed {
    logic [1:0]  ctrl;
    logic [31:0] data;
  } frame_t;

endpackage

// File: rtl/uart_frame_tx.sv
// Serializes {ctrl, data} LSB-first between a start and a stop bit, with a one-entry
// holding buffer so a queued frame follows the previous stop bit with no idle gap.
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned CTRL_W       = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [CTRL_W-1:0] tx_ctrl,
  output logic              TX,
  output logic              tx_active,
  output logic              tx_done
);

  localparam int unsigned     CntW   = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);
  localparam logic [5:0]      IdxMax = 6'(FRAME_BITS - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [5:0]      idx_q, idx_d;
  frame_t          shift_q, shift_d;
  frame_t          buf_q, buf_d;
  logic            buf_full_q, buf_full_d;
  logic            tx_q, tx_d;
  logic            active_q, active_d;
  logic            done_q, done_d;
  logic            accept, bit_end, load_direct;
  frame_t          in_frame;

  assign in_frame  = '{ctrl: tx_ctrl, data: tx_data};
  assign tx_ready  = ~buf_full_q;
  assign accept    = tx_valid & ~buf_full_q;
  assign bit_end   = (cnt_q == CntMax);
  assign TX        = tx_q;
  assign tx_active = active_q;
  assign tx_done   = done_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    buf_d       = buf_q;
    buf_full_d  = buf_full_q;
    load_direct = 1'b0;

    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = START;
          load_direct = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == IdxMax) begin
            state_d = STOP;
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = frame_t'(shift_q >> 1);
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (buf_full_q) begin
            state_d    = START;
            shift_d    = buf_q;
            buf_full_d = 1'b0;
          end else if (accept) begin
            // A word arriving on the final stop cycle bypasses the buffer.
            state_d     = START;
            load_direct = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_direct) begin
      shift_d = in_frame;
    end else if (accept) begin
      buf_d      = in_frame;
      buf_full_d = 1'b1;
    end

    // Outputs are registered from next state so they line up with the state they describe.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    active_d = (state_d != IDLE);
    done_d   = (state_d == STOP) && (cnt_d == CntMax);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      tx_q       <= 1'b1;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      tx_q       <= tx_d;
      active_q   <= active_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench: fast instance (4 clocks/bit) with a line monitor, slow instance (434) with
// a mid-bit sampling receiver model.
module tb_uart_frame_tx;

  localparam int unsigned Cpb      = 4;
  localparam int unsigned SlowCpb  = 434;
  localparam int unsigned FrameCyc = 36 * Cpb;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        tx_valid = 1'b0;
  logic [31:0] tx_data = '0;
  logic [1:0]  tx_ctrl = '0;
  logic        tx_ready, TX, tx_active, tx_done;

  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic [1:0]  s_ctrl = '0;
  logic        s_ready, s_tx, s_active, s_done;

  uart_frame_tx #(.CLKS_PER_BIT(Cpb)) u_dut (
    .CLK(CLK), .RST(RST), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_ctrl(tx_ctrl), .TX(TX), .tx_active(tx_active), .tx_done(tx_done)
  );

  uart_frame_tx #(.CLKS_PER_BIT(SlowCpb)) u_dut_slow (
    .CLK(CLK), .RST(RST), .tx_valid(s_valid), .tx_ready(s_ready), .tx_data(s_data),
    .tx_ctrl(s_ctrl), .TX(s_tx), .tx_active(s_active), .tx_done(s_done)
  );

  always #5 CLK = ~CLK;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Line monitor for the fast instance.
  logic [33:0] rx_q[$];
  int unsigned start_q[$];
  int unsigned cyc_now = 0, done_cnt = 0, done_bad = 0, act_bad = 0, frame_bad = 0, glitch = 0;
  int unsigned fcyc = 0;
  logic        in_frame = 1'b0;
  logic        mon_rst = 1'b0;
  logic [35:0] bits = '0;

  always @(posedge CLK) if (RST) mon_rst = 1'b1;

  always @(negedge CLK) begin
    cyc_now++;
    if (mon_rst) begin
      in_frame = 1'b0;
      mon_rst  = 1'b0;
    end else begin
      if (!in_frame && TX === 1'b0) begin
        in_frame = 1'b1;
        fcyc     = 0;
        start_q.push_back(cyc_now);
      end else if (in_frame) begin
        fcyc++;
      end
      if (in_frame) begin
        if (tx_active !== 1'b1) act_bad++;
        if (fcyc % Cpb == 0) bits[fcyc/Cpb] = TX;
        else if (TX !== bits[fcyc/Cpb]) glitch++;
      end
      if (tx_done === 1'b1) begin
        done_cnt++;
        if (!(in_frame && fcyc == FrameCyc - 1)) done_bad++;
      end
      if (in_frame && fcyc == FrameCyc - 1) begin
        if (bits[0] !== 1'b0 || bits[35] !== 1'b1) frame_bad++;
        rx_q.push_back(bits[34:1]);
        in_frame = 1'b0;
      end
    end
  end

  // Call at a negedge; holds valid until accepted, returns at the negedge after the accept edge.
  task automatic send(input logic [31:0] d, input logic [1:0] c, output int unsigned waited);
    waited   = 0;
    tx_valid = 1'b1;
    tx_data  = d;
    tx_ctrl  = c;
    while (tx_ready !== 1'b1 && waited < 1000) begin
      @(negedge CLK);
      waited++;
    end
    if (waited >= 1000) check_eq("send_ready", tx_ready, 1'b1);
    @(negedge CLK);
    tx_valid = 1'b0;
    tx_data  = $urandom;
    tx_ctrl  = 2'($urandom);
  endtask

  task automatic wait_frames(input int unsigned n);
    int unsigned k = 0;
    while (rx_q.size() < n && k < 2000) begin
      @(negedge CLK);
      k++;
    end
    check_eq("frames_rx", rx_q.size(), n);
  endtask

  task automatic wait_idle();
    int unsigned k = 0;
    while (tx_active === 1'b1 && k < 2000) begin
      @(negedge CLK);
      k++;
    end
    check_eq("went_idle", tx_active, 1'b0);
  endtask

  initial begin
    int unsigned w, d0, toggles;
    logic [2:0]  prev;
    logic [35:0] rbits;
    int unsigned sdone;

    // Reset and quiet idle line.
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    check_eq("rst_tx", TX, 1'b1);
    check_eq("rst_ready", tx_ready, 1'b1);
    check_eq("rst_active", tx_active, 1'b0);
    check_eq("rst_done", tx_done, 1'b0);
    toggles = 0;
    prev    = {TX, tx_active, tx_done};
    repeat (200) begin
      @(negedge CLK);
      if ({TX, tx_active, tx_done} !== prev) toggles++;
      prev = {TX, tx_active, tx_done};
    end
    check_eq("idle_toggles", toggles, 0);

    // Single frame.
    d0 = done_cnt;
    send(32'hA5A50F0F, 2'b10, w);
    check_eq("single_tx_fall", TX, 1'b0);
    check_eq("single_active", tx_active, 1'b1);
    wait_frames(1);
    check_eq("single_word", rx_q.pop_front(), {2'b10, 32'hA5A50F0F});
    check_eq("single_done_cnt", done_cnt - d0, 1);
    wait_idle();
    check_eq("single_glitch", glitch, 0);
    check_eq("single_framing", frame_bad, 0);
    check_eq("single_done_pos", done_bad, 0);

    // Back-to-back with a third frame held while the buffer is full.
    start_q.delete();
    d0 = done_cnt;
    send(32'h00000001, 2'b00, w);
    send(32'hFFFFFFFF, 2'b11, w);
    check_eq("b2b_second_immediate", w, 0);
    check_eq("b2b_ready_low", tx_ready, 1'b0);
    send(32'h12345678, 2'b01, w);
    check_eq("b2b_third_wait", w, 143);
    wait_frames(3);
    check_eq("b2b_word0", rx_q.pop_front(), {2'b00, 32'h00000001});
    check_eq("b2b_word1", rx_q.pop_front(), {2'b11, 32'hFFFFFFFF});
    check_eq("b2b_word2", rx_q.pop_front(), {2'b01, 32'h12345678});
    check_eq("b2b_gap01", start_q[1] - start_q[0], FrameCyc);
    check_eq("b2b_gap12", start_q[2] - start_q[1], FrameCyc);
    check_eq("b2b_done_cnt", done_cnt - d0, 3);
    wait_idle();
    check_eq("b2b_active_held", act_bad, 0);
    check_eq("b2b_glitch", glitch, 0);
    check_eq("b2b_framing", frame_bad, 0);
    check_eq("b2b_done_pos", done_bad, 0);

    // Reset during data bit 10 with a frame queued behind it.
    d0 = done_cnt;
    send(32'h0F0F1234, 2'b11, w);
    send(32'hCAFEF00D, 2'b10, w);
    check_eq("mid_ready_full", tx_ready, 1'b0);
    repeat (44) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check_eq("mid_rst_tx", TX, 1'b1);
    check_eq("mid_rst_active", tx_active, 1'b0);
    check_eq("mid_rst_ready", tx_ready, 1'b1);
    check_eq("mid_rst_done", tx_done, 1'b0);
    repeat (300) @(negedge CLK);
    check_eq("mid_no_done", done_cnt - d0, 0);
    check_eq("mid_no_frames", rx_q.size(), 0);
    send(32'h600DCAFE, 2'b01, w);
    wait_frames(1);
    check_eq("post_rst_word", rx_q.pop_front(), {2'b01, 32'h600DCAFE});
    wait_idle();
    check_eq("post_rst_framing", frame_bad, 0);

    // Loopback through a mid-bit sampling receiver at 434 clocks per bit.
    s_valid = 1'b1;
    s_data  = 32'hDEADBEEF;
    s_ctrl  = 2'b01;
    @(negedge CLK);
    s_valid = 1'b0;
    s_data  = '0;
    s_ctrl  = '0;
    rbits   = '1;
    sdone   = 0;
    for (int c = 0; c < 36 * SlowCpb; c++) begin
      if (c % SlowCpb == SlowCpb / 2) rbits[c/SlowCpb] = s_tx;
      if (s_done === 1'b1) sdone++;
      @(negedge CLK);
    end
    check_eq("lb_start", rbits[0], 1'b0);
    check_eq("lb_data", rbits[32:1], 32'hDEADBEEF);
    check_eq("lb_ctrl", rbits[34:33], 2'b01);
    check_eq("lb_stop", rbits[35], 1'b1);
    check_eq("lb_done_cnt", sdone, 1);
    check_eq("lb_idle", s_active, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
